// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: request/response bundle between requesters and the shared logic unit
interface logic_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [2*NREQ-1:0]       req_op;
  logic [WIDTH*NREQ-1:0]   req_a;
  logic [WIDTH*NREQ-1:0]   req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [WIDTH-1:0]        rsp_data;
  logic                    busy;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one bitwise AND/OR/XOR/NOT unit among NREQ requesters; LOGIC_ARB_RR_EN selects round-robin, else fixed priority
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  logic_unit_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] gnt, idx, id_q, rsp_id_q;
  logic gnt_ok, accept;
  logic [1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, result, rsp_data_q;
  logic [1:0] op_arr [NREQ];
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = bus.req_op[2*i +: 2];
    assign a_arr[i]  = bus.req_a[WIDTH*i +: WIDTH];
    assign b_arr[i]  = bus.req_b[WIDTH*i +: WIDTH];
  end
`ifdef LOGIC_ARB_RR_EN
  logic [IW-1:0] ptr;
  // search start moves just past the requester whose response completed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (state == RESP && bus.rsp_ready) ptr <= (rsp_id_q == IW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
`else
  localparam logic [IW-1:0] ptr = '0;
`endif
  // first valid requester at or after ptr, wrapping
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!gnt_ok && bus.req_valid[idx]) begin
        gnt = idx;
        gnt_ok = 1'b1;
      end
    end
  end
  assign bus.req_ready = (state == IDLE && gnt_ok && rst_n) ? NREQ'(1) << gnt : '0;
  assign accept = |bus.req_ready;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // IDLE waits for an accept, EXEC always lasts one cycle, RESP waits on the consumer
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (accept ? EXEC : IDLE) :
               (state == EXEC) ? RESP :
               (bus.rsp_ready ? IDLE : RESP);
  end
  // the shared bitwise unit
  always_comb begin
    result = '0;
    result = (op_q == 2'b00) ? a_q & b_q :
             (op_q == 2'b01) ? a_q | b_q :
             (op_q == 2'b10) ? a_q ^ b_q : ~a_q;
  end
  // operand capture on accept, result/id registration in EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op_arr[gnt];
        a_q <= a_arr[gnt];
        b_q <= b_arr[gnt];
        id_q <= gnt;
      end
      if (state == EXEC) begin
        rsp_data_q <= result;
        rsp_id_q <= id_q;
      end
    end
  assign bus.rsp_valid = state == RESP;
  assign bus.busy = state != IDLE;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed table, corner sequences and random traffic against a transaction-level model
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef LOGIC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic_unit_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();
  logic_unit_arbiter #(.NREQ(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vecs = 0;
  int errs = 0;
  int m_busy = 0;
  int m_resp = 0;
  int m_ptr = 0;
  int m_id = 0;
  logic [7:0] m_data = '0;
  int grants [$];
  logic [7:0] hold_d;
  logic [1:0] hold_id;
  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    return op == 2'd0 ? (a & b) : op == 2'd1 ? (a | b) : op == 2'd2 ? (a ^ b) : ~a;
  endfunction

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // one clock: check the DUT against the model, then advance the model past the rising edge
  task automatic cycle();
    int g;
    #1;
    g = (m_busy == 0) ? pick(bus.req_valid, m_ptr) : -1;
    chk("req_ready", bus.req_ready, g < 0 ? 32'd0 : 32'd1 << g);
    chk("busy", bus.busy, m_busy != 0);
    chk("rsp_valid", bus.rsp_valid, m_resp != 0);
    if (m_resp != 0) begin
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_data", bus.rsp_data, m_data);
    end
    if (g >= 0) begin
      m_id = g;
      m_data = f(bus.req_op[2*g +: 2], bus.req_a[8*g +: 8], bus.req_b[8*g +: 8]);
      grants.push_back(g);
      m_busy = 1;
    end else if (m_busy != 0 && m_resp == 0) m_resp = 1;
    else if (m_resp != 0 && bus.rsp_ready) begin
      m_ptr = RR ? (m_id + 1) % N : 0;
      m_busy = 0;
      m_resp = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_busy = 0;
    m_resp = 0;
    m_ptr = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
  endtask

  initial begin
    tbl[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30};
    tbl[1] = '{2'b01, 8'hF0, 8'h3C, 8'hFC};
    tbl[2] = '{2'b10, 8'hF0, 8'h3C, 8'hCC};
    tbl[3] = '{2'b11, 8'hF0, 8'h3C, 8'h0F};
    bus.req_valid = '1;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    #3 chk_reset_outputs("reset");
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    foreach (tbl[i]) begin
      bus.req_valid = 4'b0010;
      bus.req_op = {4{tbl[i].op}};
      bus.req_a = {4{tbl[i].a}};
      bus.req_b = {4{tbl[i].b}};
      #1 chk("tbl_ready", bus.req_ready, 4'b0010);
      cycle();
      bus.req_valid = '0;
      cycle();
      #1;
      chk("tbl_rsp_valid", bus.rsp_valid, 1);
      chk("tbl_rsp_id", bus.rsp_id, 1);
      chk("tbl_rsp_data", bus.rsp_data, tbl[i].y);
      cycle();
    end
    do_reset();
    grants.delete();
    bus.req_valid = 4'hF;
    bus.req_op = 8'b11_10_01_00;
    bus.req_a = 32'h1234_5678;
    bus.req_b = 32'h0F0F_F0F0;
    repeat (15) cycle();
    for (int i = 0; i < 5; i++)
      chk("arb_order", grants.size() > i ? grants[i] : -1, RR ? i % N : 0);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    cycle();
    bus.req_valid = 4'b0000;
    cycle();
    #1;
    hold_d = bus.rsp_data;
    hold_id = bus.rsp_id;
    repeat (5) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, hold_d);
      chk("bp_id", bus.rsp_id, hold_id);
      cycle();
    end
    bus.rsp_ready = 1'b1;
    cycle();
    #1;
    chk("bp_done_busy", bus.busy, 0);
    chk("bp_done_valid", bus.rsp_valid, 0);
    do_reset();
    bus.req_valid = 4'b0100;
    repeat (3) cycle();
    grants.delete();
    bus.req_valid = 4'b0101;
    repeat (6) cycle();
    chk("wrap_first", grants.size() > 0 ? grants[0] : -1, 0);
    chk("wrap_second", grants.size() > 1 ? grants[1] : -1, RR ? 2 : 0);
    bus.req_valid = '0;
    repeat (3) cycle();
    do_reset();
    bus.req_valid = 4'b0010;
    repeat (3) cycle();
    bus.req_valid = 4'b1000;
    cycle();
    bus.req_valid = 4'b1010;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    m_busy = 0;
    m_resp = 0;
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
    repeat (3) cycle();
    grants.delete();
    bus.req_valid = 4'b1010;
    cycle();
    chk("midrst_grant", grants.size() > 0 ? grants[0] : -1, 1);
    bus.req_valid = '0;
    repeat (3) cycle();
    repeat (10) cycle();
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = 4'($urandom);
      bus.req_op = 8'($urandom);
      bus.req_a = $urandom;
      bus.req_b = $urandom;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
